// File: rtl/green_hv_sched_if.sv
// Bundle of request, datapath and result signals around green_hv_sched.
// slave: the scheduler side; master: requesters, datapath and consumers.
interface green_hv_sched_if #(
  parameter int DW = 12,
  parameter int OW = 14
);
  logic          h_valid;
  logic          h_ready;
  logic [DW-1:0] h_m2, h_m1, h_c, h_p1, h_p2;
  logic          v_valid;
  logic          v_ready;
  logic [DW-1:0] v_m2, v_m1, v_c, v_p1, v_p2;
  logic [DW-1:0] dp_m2, dp_m1, dp_c, dp_p1, dp_p2;
  logic          dp_valid;
  logic [OW-1:0] dp_out;
  logic          h_out_valid;
  logic [OW-1:0] h_out;
  logic          h_out_ready;
  logic          v_out_valid;
  logic [OW-1:0] v_out;
  logic          v_out_ready;

  modport slave (
    input  h_valid, h_m2, h_m1, h_c, h_p1, h_p2,
    output h_ready,
    input  v_valid, v_m2, v_m1, v_c, v_p1, v_p2,
    output v_ready,
    output dp_m2, dp_m1, dp_c, dp_p1, dp_p2, dp_valid,
    input  dp_out,
    output h_out_valid, h_out,
    input  h_out_ready,
    output v_out_valid, v_out,
    input  v_out_ready
  );

  modport master (
    output h_valid, h_m2, h_m1, h_c, h_p1, h_p2,
    input  h_ready,
    output v_valid, v_m2, v_m1, v_c, v_p1, v_p2,
    input  v_ready,
    input  dp_m2, dp_m1, dp_c, dp_p1, dp_p2, dp_valid,
    output dp_out,
    input  h_out_valid, h_out,
    output h_out_ready,
    input  v_out_valid, v_out,
    output v_out_ready
  );
endinterface

// File: rtl/green_hv_sched.sv
// Shares one green_h_v interpolation datapath between H and V tap requesters.
// Round-robin grant, per-direction credits sized to the result FIFOs, and a
// tag pipeline that routes each datapath result into its direction's FIFO.
// Optional build macro GHV_STATS_EN adds saturating grant/stall counters.
//
// state | meaning
// RR_H  | last grant went to H; V wins the next tie
// RR_V  | last grant went to V (reset); H wins the next tie
module green_hv_sched #(
  parameter int DW         = 12,
  parameter int OW         = 14,
  parameter int DP_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  green_hv_sched_if.slave bus
`ifdef GHV_STATS_EN
  ,
  output logic [15:0] h_grant_cnt,
  output logic [15:0] v_grant_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RR_H = 1'b0, RR_V = 1'b1} rr_t;
  rr_t rr_last, rr_next;

  // index 0 = H, index 1 = V throughout
  logic [1:0] req, credit, elig, grant, push, pop, out_rdy;
  logic [CW-1:0] infl [2];
  logic [CW-1:0] cnt [2];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [OW-1:0] mem [2][FIFO_DEPTH];
  logic [DP_LAT-1:0] tag_vld, tag_dir;
  logic dp_dir;

  assign req     = {bus.v_valid, bus.h_valid};
  assign out_rdy = {bus.v_out_ready, bus.h_out_ready};
  assign elig    = req & credit;
  assign push    = {tag_vld[DP_LAT-1] & tag_dir[DP_LAT-1],
                    tag_vld[DP_LAT-1] & ~tag_dir[DP_LAT-1]};

  // credit from registered occupancy only; pops free space a cycle later
  always_comb begin
    credit = '0;
    pop    = '0;
    for (int d = 0; d < 2; d++) begin
      credit[d] = ((CW+1)'(infl[d]) + (CW+1)'(cnt[d])) < (CW+1)'(FIFO_DEPTH);
      pop[d]    = (cnt[d] != '0) & out_rdy[d];
    end
  end

  // round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last <= RR_V;
    else     rr_last <= rr_next;
  end

  // grant selection and pointer update
  always_comb begin
    grant   = '0;
    rr_next = rr_last;
    if (elig[0] && (!elig[1] || rr_last == RR_V)) begin
      grant[0] = 1'b1;
      rr_next  = RR_H;
    end else if (elig[1]) begin
      grant[1] = 1'b1;
      rr_next  = RR_V;
    end
  end

  assign bus.h_ready = grant[0];
  assign bus.v_ready = grant[1];

  // issue register: taps hold their last value when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dp_m2    <= '0;
      bus.dp_m1    <= '0;
      bus.dp_c     <= '0;
      bus.dp_p1    <= '0;
      bus.dp_p2    <= '0;
      bus.dp_valid <= 1'b0;
      dp_dir       <= 1'b0;
    end else begin
      bus.dp_valid <= |grant;
      if (grant[0]) begin
        bus.dp_m2 <= bus.h_m2;
        bus.dp_m1 <= bus.h_m1;
        bus.dp_c  <= bus.h_c;
        bus.dp_p1 <= bus.h_p1;
        bus.dp_p2 <= bus.h_p2;
        dp_dir    <= 1'b0;
      end else if (grant[1]) begin
        bus.dp_m2 <= bus.v_m2;
        bus.dp_m1 <= bus.v_m1;
        bus.dp_c  <= bus.v_c;
        bus.dp_p1 <= bus.v_p1;
        bus.dp_p2 <= bus.v_p2;
        dp_dir    <= 1'b1;
      end
    end
  end

  // tag pipeline: last stage lines up with the cycle dp_out is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_dir <= '0;
    end else begin
      tag_vld[0] <= bus.dp_valid;
      tag_dir[0] <= dp_dir;
      for (int i = 1; i < DP_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_dir[i] <= tag_dir[i-1];
      end
    end
  end

  // in-flight counters and result FIFOs for both directions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        infl[d] <= '0;
        cnt[d]  <= '0;
        wp[d]   <= '0;
        rp[d]   <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[d][i] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (grant[d] && !push[d])      infl[d] <= infl[d] + 1'b1;
        else if (!grant[d] && push[d]) infl[d] <= infl[d] - 1'b1;
        if (push[d]) begin
          mem[d][wp[d]] <= bus.dp_out;
          wp[d]         <= wp[d] + 1'b1;
        end
        if (pop[d]) rp[d] <= rp[d] + 1'b1;
        if (push[d] && !pop[d])      cnt[d] <= cnt[d] + 1'b1;
        else if (!push[d] && pop[d]) cnt[d] <= cnt[d] - 1'b1;
      end
    end
  end

  assign bus.h_out_valid = (cnt[0] != '0);
  assign bus.h_out       = mem[0][rp[0]];
  assign bus.v_out_valid = (cnt[1] != '0);
  assign bus.v_out       = mem[1][rp[1]];

`ifdef GHV_STATS_EN
  // saturating grant and credit-stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_grant_cnt <= '0;
      v_grant_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (grant[0] && h_grant_cnt != 16'hFFFF) h_grant_cnt <= h_grant_cnt + 1'b1;
      if (grant[1] && v_grant_cnt != 16'hFFFF) v_grant_cnt <= v_grant_cnt + 1'b1;
      if ((|(req & ~credit)) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_green_hv_sched.sv
// Bench for green_hv_sched: vector table for backpressure, hand sequences for
// first issue, tie, idle and mid-operation reset, then randomized traffic
// against a queue-based reference of accepted requests.
module tb_green_hv_sched;
  localparam int DW = 12, OW = 14, DP_LAT = 2, FD = 4, LAT = DP_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  green_hv_sched_if #(.DW(DW), .OW(OW)) bus ();
`ifdef GHV_STATS_EN
  logic [15:0] h_grant_cnt, v_grant_cnt, stall_cnt;
`endif

  green_hv_sched #(.DW(DW), .OW(OW), .DP_LAT(DP_LAT), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef GHV_STATS_EN
    ,
    .h_grant_cnt (h_grant_cnt),
    .v_grant_cnt (v_grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // datapath model: fixed DP_LAT-cycle delay of a function of the taps
  logic fixed_en = 1'b0;
  logic [OW-1:0] fixed_val = 14'd1234;
  function automatic logic [OW-1:0] dp_fn(input logic [DW-1:0] a, b, c, d, e);
    int s;
    if (fixed_en) return fixed_val;
    s = int'(a) + 2 * int'(b) + 3 * int'(c) + 5 * int'(d) + 7 * int'(e);
    return s[OW-1:0];
  endfunction

  logic [OW-1:0] pipe [DP_LAT];
  always @(posedge clk) begin
    pipe[0] <= dp_fn(bus.dp_m2, bus.dp_m1, bus.dp_c, bus.dp_p1, bus.dp_p2);
    for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dp_out = pipe[DP_LAT-1];

  // reference: per-direction queue of accepted requests (cycle, result)
  typedef struct {
    int            cyc;
    logic [OW-1:0] val;
  } ent_t;
  ent_t hq[$], vq[$];
  logic last_h = 1'b0;
  logic h_pend = 1'b0, v_pend = 1'b0;
  logic [DW-1:0] last_taps [5];

  always @(negedge clk) begin
    bit eh, ev, xh, xv;
    if (rst) begin
      hq.delete();
      vq.delete();
      last_h = 1'b0;
      h_pend = 1'b0;
      v_pend = 1'b0;
    end else begin
      eh = bus.h_valid && (hq.size() < FD);
      ev = bus.v_valid && (vq.size() < FD);
      xh = eh && (!ev || !last_h);
      xv = ev && !xh;
      chk1("arb_h_ready", bus.h_ready, xh);
      chk1("arb_v_ready", bus.v_ready, xv);
      chk1("h_out_valid", bus.h_out_valid, hq.size() > 0 && hq[0].cyc + LAT <= cyc);
      chk1("v_out_valid", bus.v_out_valid, vq.size() > 0 && vq[0].cyc + LAT <= cyc);
      if (bus.h_out_valid && bus.h_out_ready && hq.size() > 0) begin
        chkv("h_out_data", 32'(bus.h_out), 32'(hq[0].val));
        void'(hq.pop_front());
      end
      if (bus.v_out_valid && bus.v_out_ready && vq.size() > 0) begin
        chkv("v_out_data", 32'(bus.v_out), 32'(vq[0].val));
        void'(vq.pop_front());
      end
      if (bus.h_valid && bus.h_ready) begin
        hq.push_back('{cyc: cyc, val: dp_fn(bus.h_m2, bus.h_m1, bus.h_c, bus.h_p1, bus.h_p2)});
        last_h = 1'b1;
        last_taps = '{bus.h_m2, bus.h_m1, bus.h_c, bus.h_p1, bus.h_p2};
      end else if (bus.v_valid && bus.v_ready) begin
        vq.push_back('{cyc: cyc, val: dp_fn(bus.v_m2, bus.v_m1, bus.v_c, bus.v_p1, bus.v_p2)});
        last_h = 1'b0;
        last_taps = '{bus.v_m2, bus.v_m1, bus.v_c, bus.v_p1, bus.v_p2};
      end
      h_pend = bus.h_valid && !bus.h_ready;
      v_pend = bus.v_valid && !bus.v_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // new taps only when the previous offer was not left pending
  task automatic drive(input logic hv, input logic vv, input logic hor, input logic vor);
    if (!h_pend) begin
      bus.h_m2 = DW'($urandom); bus.h_m1 = DW'($urandom); bus.h_c = DW'($urandom);
      bus.h_p1 = DW'($urandom); bus.h_p2 = DW'($urandom);
    end
    if (!v_pend) begin
      bus.v_m2 = DW'($urandom); bus.v_m1 = DW'($urandom); bus.v_c = DW'($urandom);
      bus.v_p1 = DW'($urandom); bus.v_p2 = DW'($urandom);
    end
    bus.h_valid = hv;
    bus.v_valid = vv;
    bus.h_out_ready = hor;
    bus.v_out_ready = vor;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic hv, vv, hor, vor;
    logic hr, vr, hov;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int h_bias, v_bias;
    logic hv, vv;

    // backpressure: H consumer stalled, V joins at cycle 10, H drains at 14
    repeat (4) tbl.push_back('{1, 0, 0, 1, 1, 0, 0});
    repeat (6) tbl.push_back('{1, 0, 0, 1, 0, 0, 1});
    repeat (4) tbl.push_back('{1, 1, 0, 1, 0, 1, 1});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 1});
    repeat (3) tbl.push_back('{1, 0, 1, 1, 1, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 1});

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // reset values and first issue
    chk1("rst_dp_valid", bus.dp_valid, 1'b0);
    chkv("rst_dp_c", 32'(bus.dp_c), 32'd0);
    chkv("rst_h_out", 32'(bus.h_out), 32'd0);
    fixed_en = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    bus.h_m2 = 12'd100; bus.h_m1 = 12'd200; bus.h_c = 12'd300;
    bus.h_p1 = 12'd400; bus.h_p2 = 12'd500;
    @(negedge clk);
    chk1("first_h_ready", bus.h_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk1("first_dp_valid", bus.dp_valid, 1'b1);
    chkv("first_dp_m2", 32'(bus.dp_m2), 32'd100);
    chkv("first_dp_m1", 32'(bus.dp_m1), 32'd200);
    chkv("first_dp_c", 32'(bus.dp_c), 32'd300);
    chkv("first_dp_p1", 32'(bus.dp_p1), 32'd400);
    chkv("first_dp_p2", 32'(bus.dp_p2), 32'd500);
    tick();
    tick();
    @(negedge clk);
    chk1("first_out_valid_c3", bus.h_out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("first_out_valid_c4", bus.h_out_valid, 1'b1);
    chkv("first_h_out", 32'(bus.h_out), 32'd1234);
    tick();
    fixed_en = 1'b0;

    // tie arbitration, then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk1("tie_h_ready", bus.h_ready, (i % 2) == 0);
      chk1("tie_v_ready", bus.v_ready, (i % 2) == 1);
      if (i > 0) chk1("tie_dp_valid", bus.dp_valid, 1'b1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      if (i > 0) begin
        chk1("idle_dp_valid", bus.dp_valid, 1'b0);
        chkv("idle_dp_m2", 32'(bus.dp_m2), 32'(last_taps[0]));
        chkv("idle_dp_c", 32'(bus.dp_c), 32'(last_taps[2]));
        chkv("idle_dp_p2", 32'(bus.dp_p2), 32'(last_taps[4]));
      end
      tick();
    end

    // backpressure vector table
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].hv, tbl[i].vv, tbl[i].hor, tbl[i].vor);
      @(negedge clk);
      chk1("bp_h_ready", bus.h_ready, tbl[i].hr);
      chk1("bp_v_ready", bus.v_ready, tbl[i].vr);
      chk1("bp_h_out_valid", bus.h_out_valid, tbl[i].hov);
`ifdef GHV_STATS_EN
      if (i == 10) begin
        chkv("stats_h_grant", 32'(h_grant_cnt), 32'd4);
        chkv("stats_v_grant", 32'(v_grant_cnt), 32'd0);
        chkv("stats_stall", 32'(stall_cnt), 32'd6);
      end
`endif
      tick();
    end
    repeat (10) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end

    // reset with 2 H results in flight and 3 V results queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i >= 3 && i < 5, i < 3, 1'b0, 1'b0);
      @(negedge clk);
      tick();
    end
    chk1("pre_rst_v_out_valid", bus.v_out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrst_dp_valid", bus.dp_valid, 1'b0);
    chkv("midrst_dp_m2", 32'(bus.dp_m2), 32'd0);
    chk1("midrst_h_out_valid", bus.h_out_valid, 1'b0);
    chk1("midrst_v_out_valid", bus.v_out_valid, 1'b0);
    chkv("midrst_v_out", 32'(bus.v_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk1("post_rst_h_out_valid", bus.h_out_valid, 1'b0);
      chk1("post_rst_v_out_valid", bus.v_out_valid, 1'b0);
      tick();
    end

    // randomized traffic with shifting consumer stall bias
    do_reset();
    h_bias = 0;
    v_bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        h_bias = $urandom_range(0, 3);
        v_bias = $urandom_range(0, 3);
      end
      hv = h_pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      vv = v_pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(hv, vv, $urandom_range(0, 3) >= h_bias, $urandom_range(0, 3) >= v_bias);
      tick();
    end
    repeat (12) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
